// File: rtl/lut_cell_seq_if.sv
// Config and evaluation bus of the programmable LUT cell.
// The master drives configuration and inputs; the slave returns results.
interface lut_cell_seq_if #(
  parameter int N_IN = 2
);
  logic            cfg_en;
  logic            cfg_bit;
  logic            cfg_done;
  logic            table_valid;
  logic [N_IN-1:0] in;
  logic            in_valid;
  logic            out;
  logic            out_valid;

  modport master (
    output cfg_en, cfg_bit, in, in_valid,
    input  cfg_done, table_valid, out, out_valid
  );

  modport slave (
    input  cfg_en, cfg_bit, in, in_valid,
    output cfg_done, table_valid, out, out_valid
  );
endinterface

// File: rtl/lut_cell_seq.sv
// Runtime-programmable lookup cell with a serially loaded truth table.
// MODE=1 feeds the state bit back as the table index LSB (sequential UDP).
module lut_cell_seq #(
  parameter int N_IN    = 2,
  parameter int MODE    = 0,
  parameter bit INIT_Q  = 1'b0,
  parameter int TABLE_W = 2**(N_IN+MODE)
) (
  input  logic           clk,
  input  logic           rst,
  lut_cell_seq_if.slave  bus
);
  localparam int IW = N_IN + MODE;
  localparam int CW = (TABLE_W > 1) ? $clog2(TABLE_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(TABLE_W - 1);
  localparam logic RST_OUT = (MODE == 1) ? INIT_Q : 1'b0;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TABLE_W-1:0]   shadow_q, shadow_d;
  logic [TABLE_W-1:0]   tbl_q, tbl_d;
  logic                 done_q, done_d;
  logic                 tv_q, tv_d;
  logic                 out_q, out_d;
  logic                 ov_q, ov_d;
  logic [IW-1:0]        idx;

  generate
    if (MODE == 1) begin : g_seq
      assign idx = {bus.in, out_q};
    end else begin : g_comb
      assign idx = bus.in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      tbl_q    <= '0;
      done_q   <= 1'b0;
      tv_q     <= 1'b0;
      out_q    <= RST_OUT;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tbl_q    <= tbl_d;
      done_q   <= done_d;
      tv_q     <= tv_d;
      out_q    <= out_d;
      ov_q     <= ov_d;
    end
  end

  // The last bit is merged into the commit so the new table lands on the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tbl_d    = tbl_q;
    done_d   = 1'b0;
    tv_d     = tv_q;
    if (bus.cfg_en) begin
      shadow_d[cnt_q] = bus.cfg_bit;
      if (cnt_q == LAST) begin
        tbl_d   = shadow_d;
        cnt_d   = '0;
        done_d  = 1'b1;
        tv_d    = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = LOAD;
      end
    end
  end

  // Evaluation reads the registered table, so a commit edge still sees the old one.
  always_comb begin
    out_d = out_q;
    ov_d  = 1'b0;
    if (bus.in_valid && tv_q) begin
      out_d = tbl_q[idx];
      ov_d  = 1'b1;
    end
  end

  assign bus.cfg_done    = done_q;
  assign bus.table_valid = tv_q;
  assign bus.out         = out_q;
  assign bus.out_valid   = ov_q;
endmodule

// File: tb/tb_lut_cell_seq.sv
// Directed bench: combinational 2-input cell via a vector table,
// plus hand-written sequences for gapped/aborted loads and a 1-input toggle cell.
module tb_lut_cell_seq;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lut_cell_seq_if #(.N_IN(2)) ifa ();
  lut_cell_seq_if #(.N_IN(1)) ifb ();

  lut_cell_seq #(.N_IN(2), .MODE(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa)
  );
  lut_cell_seq #(.N_IN(1), .MODE(1), .INIT_Q(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  typedef struct packed {
    logic       ce;
    logic       cb;
    logic [1:0] in;
    logic       iv;
    logic       eo;
    logic       eov;
    logic       edone;
    logic       etv;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic ce, input logic cb, input logic [1:0] in, input logic iv);
    ifa.cfg_en = ce; ifa.cfg_bit = cb; ifa.in = in; ifa.in_valid = iv;
    step();
  endtask

  task automatic drv_b(input logic ce, input logic cb, input logic in, input logic iv);
    ifb.cfg_en = ce; ifb.cfg_bit = cb; ifb.in = in; ifb.in_valid = iv;
    step();
  endtask

  task automatic chk_a(input string name, input logic eo, input logic eov,
                       input logic edone, input logic etv);
    chk({name, ".out"},         {31'd0, ifa.out},         {31'd0, eo});
    chk({name, ".out_valid"},   {31'd0, ifa.out_valid},   {31'd0, eov});
    chk({name, ".cfg_done"},    {31'd0, ifa.cfg_done},    {31'd0, edone});
    chk({name, ".table_valid"}, {31'd0, ifa.table_valid}, {31'd0, etv});
  endtask

  initial begin
    logic [3:0] bits;
    int         pulses;
    //            ce  cb  in     iv  eo  eov dn  tv
    vt[0]  = '{1'b0,1'b0,2'b11,1'b1,1'b0,1'b0,1'b0,1'b0}; // eval before config dropped
    vt[1]  = '{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0}; // AND table 0,0,0,1
    vt[2]  = '{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    vt[3]  = '{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    vt[4]  = '{1'b1,1'b1,2'b11,1'b1,1'b0,1'b0,1'b1,1'b1}; // first commit: input dropped
    vt[5]  = '{1'b0,1'b0,2'b11,1'b1,1'b1,1'b1,1'b0,1'b1};
    vt[6]  = '{1'b0,1'b0,2'b01,1'b1,1'b0,1'b1,1'b0,1'b1};
    vt[7]  = '{1'b0,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1}; // out holds
    vt[8]  = '{1'b0,1'b0,2'b11,1'b1,1'b1,1'b1,1'b0,1'b1};
    vt[9]  = '{1'b1,1'b0,2'b11,1'b1,1'b1,1'b1,1'b0,1'b1}; // XOR reload 0,1,1,0
    vt[10] = '{1'b1,1'b1,2'b11,1'b1,1'b1,1'b1,1'b0,1'b1};
    vt[11] = '{1'b1,1'b1,2'b11,1'b1,1'b1,1'b1,1'b0,1'b1};
    vt[12] = '{1'b1,1'b0,2'b11,1'b1,1'b1,1'b1,1'b1,1'b1}; // commit edge: old table
    vt[13] = '{1'b0,1'b0,2'b11,1'b1,1'b0,1'b1,1'b0,1'b1}; // new XOR table
    vt[14] = '{1'b0,1'b0,2'b10,1'b1,1'b1,1'b1,1'b0,1'b1};
    vt[15] = '{1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.cfg_en = 0; ifa.cfg_bit = 0; ifa.in = '0; ifa.in_valid = 0;
    ifb.cfg_en = 0; ifb.cfg_bit = 0; ifb.in = '0; ifb.in_valid = 0;
    step(); step();
    chk_a("reset_a", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_b.out", {31'd0, ifb.out}, 32'd0);
    chk("reset_b.table_valid", {31'd0, ifb.table_valid}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drv_a(vt[i].ce, vt[i].cb, vt[i].in, vt[i].iv);
      chk_a($sformatf("vec%0d", i), vt[i].eo, vt[i].eov, vt[i].edone, vt[i].etv);
    end

    // Gapped AND reload: 3 idle cycles after every bit, exactly one cfg_done
    bits = 4'b1000;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drv_a(1'b1, bits[k], 2'b00, 1'b0);
      if (ifa.cfg_done) pulses++;
      if (k == 3) chk("gap.done_on_last", {31'd0, ifa.cfg_done}, 32'd1);
      for (int g = 0; g < 3; g++) begin
        drv_a(1'b0, 1'b0, 2'b00, 1'b0);
        if (ifa.cfg_done) pulses++;
      end
    end
    chk("gap.pulses", pulses, 32'd1);
    drv_a(1'b0, 1'b0, 2'b10, 1'b1);
    chk_a("gap.eval10", 1'b0, 1'b1, 1'b0, 1'b1);
    drv_a(1'b0, 1'b0, 2'b11, 1'b1);
    chk_a("gap.eval11", 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset after 2 of 4 bits; reset overrides cfg_en and in_valid
    drv_a(1'b1, 1'b1, 2'b00, 1'b0);
    drv_a(1'b1, 1'b1, 2'b00, 1'b0);
    rst_a = 1'b1;
    drv_a(1'b1, 1'b1, 2'b11, 1'b1);
    rst_a = 1'b0;
    chk_a("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    drv_a(1'b0, 1'b0, 2'b11, 1'b1);
    chk_a("midrst.drop", 1'b0, 1'b0, 1'b0, 1'b0);
    // OR table 0,1,1,1 must land from bit 0
    bits = 4'b1110;
    for (int k = 0; k < 4; k++) drv_a(1'b1, bits[k], 2'b00, 1'b0);
    chk_a("or.commit", 1'b0, 1'b0, 1'b1, 1'b1);
    drv_a(1'b0, 1'b0, 2'b01, 1'b1);
    chk_a("or.eval01", 1'b1, 1'b1, 1'b0, 1'b1);
    drv_a(1'b0, 1'b0, 2'b00, 1'b1);
    chk_a("or.eval00", 1'b0, 1'b1, 1'b0, 1'b1);

    // Toggle cell: table index {t, q}, bits 0,1,1,0
    drv_b(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tog.predrop", {30'd0, ifb.out_valid, ifb.out}, 32'd0);
    bits = 4'b0110;
    for (int k = 0; k < 4; k++) drv_b(1'b1, bits[k], 1'b0, 1'b0);
    chk("tog.commit", {30'd0, ifb.cfg_done, ifb.table_valid}, 32'd3);
    drv_b(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tog.t1_a", {30'd0, ifb.out_valid, ifb.out}, 32'd3);
    drv_b(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tog.t1_b", {30'd0, ifb.out_valid, ifb.out}, 32'd2);
    drv_b(1'b0, 1'b0, 1'b1, 1'b1);
    chk("tog.t1_c", {30'd0, ifb.out_valid, ifb.out}, 32'd3);
    drv_b(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tog.t0_hold", {30'd0, ifb.out_valid, ifb.out}, 32'd3);
    drv_b(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tog.idle", {30'd0, ifb.out_valid, ifb.out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
